// File: rtl/vga_layer_arbiter_if.sv
// vga_layer_arbiter_if
// Groups the pixel, layer, configuration and status signals of the layer
// arbiter into one bundle. The master side is the sprite/compositor
// environment. The slave side is the arbiter itself.
interface vga_layer_arbiter_if #(
  parameter int N_LAYERS = 10,
  parameter int COLOR_W  = 12,
  parameter int IDX_W    = 4
);

  logic                          pix_in_valid;
  logic                          frame_start;
  logic [N_LAYERS-1:0]           layer_en;
  logic [N_LAYERS*COLOR_W-1:0]   layer_rgb;
  logic [COLOR_W-1:0]            bg_rgb;
  logic                          cfg_wr;
  logic [N_LAYERS-1:0]           cfg_mask;

  logic                          pix_valid;
  logic [COLOR_W-1:0]            pix_rgb;
  logic                          pix_en;
  logic [IDX_W-1:0]              pix_layer;
  logic [N_LAYERS-1:0]           active_mask;
  logic                          coll_flag;
  logic [15:0]                   coll_count;

  modport master (
    output pix_in_valid, frame_start, layer_en, layer_rgb, bg_rgb, cfg_wr, cfg_mask,
    input  pix_valid, pix_rgb, pix_en, pix_layer, active_mask, coll_flag, coll_count
  );

  modport slave (
    input  pix_in_valid, frame_start, layer_en, layer_rgb, bg_rgb, cfg_wr, cfg_mask,
    output pix_valid, pix_rgb, pix_en, pix_layer, active_mask, coll_flag, coll_count
  );

endinterface

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter
// Per-pixel priority arbiter for the sprite/layer compositor. Layer 0 has the
// highest priority. A double-buffered layer mask only changes at frame start.
// The pipeline has two register stages, so latency is two pixel clocks and
// throughput is one pixel per clock.
// Optional feature macro: VGA_COLLISION_EN builds the per-frame overlap counter
// (coll_flag / coll_count). Without the macro both outputs are tied to zero.
module vga_layer_arbiter #(
  parameter int N_LAYERS = 10,
  parameter int COLOR_W  = 12,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  vga_layer_arbiter_if.slave  io_bus
);

  // ---------------------------------------------------------------------
  // Mask double buffer
  // ---------------------------------------------------------------------
  logic [N_LAYERS-1:0] r_shadowMask;
  logic [N_LAYERS-1:0] r_activeMask;

  // Software writes land in the shadow copy. Frame start promotes the shadow
  // copy. A write in the same cycle as frame start goes straight through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadowMask <= '1;
      r_activeMask <= '1;
    end else begin
      if (io_bus.cfg_wr) begin
        r_shadowMask <= io_bus.cfg_mask;
      end
      if (io_bus.frame_start) begin
        r_activeMask <= io_bus.cfg_wr ? io_bus.cfg_mask : r_shadowMask;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: masking and priority encode
  // ---------------------------------------------------------------------
  logic [N_LAYERS-1:0] w_m;
  logic [IDX_W-1:0]    w_idx;
  logic [COLOR_W-1:0]  w_sel;
  logic                w_hit;

  // Pixels outside the active area are forced to "no layer" here. That makes
  // blanking fall out of the same path as an empty pixel.
  assign w_m = io_bus.pix_in_valid ? (io_bus.layer_en & r_activeMask) : '0;

  // Scan from the lowest-priority layer upwards, so the last hit written is
  // the lowest index, which is the highest-priority layer.
  always_comb begin
    w_idx = '1;
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (w_m[k]) begin
        w_idx = IDX_W'(k);
        w_sel = io_bus.layer_rgb[k*COLOR_W +: COLOR_W];
        w_hit = 1'b1;
      end
    end
  end

  logic                r_s1Valid;
  logic                r_s1Hit;
  logic [IDX_W-1:0]    r_s1Idx;
  logic [COLOR_W-1:0]  r_s1Rgb;

  // Register the encoder result together with the pixel-valid qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Hit   <= 1'b0;
      r_s1Idx   <= '1;
      r_s1Rgb   <= '0;
    end else begin
      r_s1Valid <= io_bus.pix_in_valid;
      r_s1Hit   <= w_hit;
      r_s1Idx   <= w_idx;
      r_s1Rgb   <= w_sel;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: composite output
  // ---------------------------------------------------------------------
  logic                r_pixValid;
  logic                r_pixEn;
  logic [IDX_W-1:0]    r_pixLayer;
  logic [COLOR_W-1:0]  r_pixRgb;

  // Pick the layer colour, the background, or black during blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixValid <= 1'b0;
      r_pixEn    <= 1'b0;
      r_pixLayer <= '1;
      r_pixRgb   <= '0;
    end else begin
      r_pixValid <= r_s1Valid;
      r_pixEn    <= r_s1Hit;
      r_pixLayer <= r_s1Hit ? r_s1Idx : '1;
      if (!r_s1Valid) begin
        r_pixRgb <= '0;
      end else if (r_s1Hit) begin
        r_pixRgb <= r_s1Rgb;
      end else begin
        r_pixRgb <= io_bus.bg_rgb;
      end
    end
  end

  assign io_bus.pix_valid   = r_pixValid;
  assign io_bus.pix_en      = r_pixEn;
  assign io_bus.pix_layer   = r_pixLayer;
  assign io_bus.pix_rgb     = r_pixRgb;
  assign io_bus.active_mask = r_activeMask;

  // ---------------------------------------------------------------------
  // Per-frame overlap counter
  // ---------------------------------------------------------------------
`ifdef VGA_COLLISION_EN
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } collState_t;

  collState_t  r_state;
  collState_t  w_nextState;
  logic [15:0] r_cnt;
  logic [15:0] w_cntNext;
  logic [15:0] r_collCount;
  logic [15:0] w_collCountNext;
  logic        r_collFlag;
  logic        w_collFlagNext;
  logic        w_ovl;

  // The overlap is taken from the stage-1 encoder input rather than its
  // register. That way a pixel and the frame_start pulse beside it are
  // attributed to the same frame, and coll_count changes on the edge that
  // samples frame_start.
  assign w_ovl = ($countones(w_m) >= 2);

  // Frame state register and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_collCount <= '0;
      r_collFlag  <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_cntNext;
      r_collCount <= w_collCountNext;
      r_collFlag  <= w_collFlagNext;
    end
  end

  // IDLE waits for the first frame boundary. In IDLE, overlaps are ignored
  // because the first frame is only partial. COUNT accumulates overlaps with
  // saturation and hands the total off at each frame boundary.
  always_comb begin
    w_nextState     = r_state;
    w_cntNext       = r_cnt;
    w_collCountNext = r_collCount;
    w_collFlagNext  = r_collFlag;
    case (r_state)
      IDLE: begin
        if (io_bus.frame_start) begin
          w_nextState = COUNT;
        end
      end
      COUNT: begin
        if (io_bus.frame_start) begin
          w_collCountNext = r_cnt;
          w_cntNext       = {15'd0, w_ovl};
          w_collFlagNext  = w_ovl;
        end else if (w_ovl) begin
          if (r_cnt != 16'hFFFF) begin
            w_cntNext = r_cnt + 16'd1;
          end
          w_collFlagNext = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign io_bus.coll_flag  = r_collFlag;
  assign io_bus.coll_count = r_collCount;
`else
  assign io_bus.coll_flag  = 1'b0;
  assign io_bus.coll_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// tb_vga_layer_arbiter
// Scoreboard bench for vga_layer_arbiter. The driver computes expected
// results from a behavioural model of the compositor rules and queues them
// with the cycle at which they are due. An independent monitor pops and
// compares them. Honours VGA_COLLISION_EN in the same way as the design.
module tb_vga_layer_arbiter;

  localparam int N  = 10;
  localparam int CW = 12;
  localparam int IW = 4;
`ifdef VGA_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  vga_layer_arbiter_if #(.N_LAYERS(N), .COLOR_W(CW), .IDX_W(IW)) bus ();

  vga_layer_arbiter #(.N_LAYERS(N), .COLOR_W(CW), .IDX_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    int            due;
    logic          valid;
    logic          en;
    logic [CW-1:0] rgb;
    logic [IW-1:0] layer;
  } pixExp_t;

  typedef struct {
    int            due;
    logic          flag;
    logic [15:0]   count;
    logic [N-1:0]  mask;
  } stExp_t;

  pixExp_t pixQ[$];
  stExp_t  stQ[$];

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  logic [CW-1:0] curBg;
  logic [N-1:0]  mShadow;
  logic [N-1:0]  mActive;
  bit            modelCounting;
  int            modelRun;
  bit            modelFlag;
  int            modelLast;

  // Pixel clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N*CW-1:0] randRgb();
    logic [N*CW-1:0] r;
    for (int k = 0; k < N; k++) begin
      r[k*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
    end
    return r;
  endfunction

  // Drive one pixel cycle and queue what the compositor must produce for it
  task automatic applyStimulus(input logic v, input logic [N-1:0] en, input logic [N*CW-1:0] rgb,
                               input logic wr, input logic [N-1:0] cm, input logic fs);
    logic [N-1:0] m;
    pixExp_t      pe;
    stExp_t       se;
    bit           ovl;
    int           win;
    @(negedge clk);
    bus.pix_in_valid = v;
    bus.layer_en     = en;
    bus.layer_rgb    = rgb;
    bus.bg_rgb       = curBg;
    bus.cfg_wr       = wr;
    bus.cfg_mask     = cm;
    bus.frame_start  = fs;

    m = v ? (en & mActive) : '0;
    win = N;
    for (int k = 0; k < N; k++) begin
      if (m[k] && win == N) win = k;
    end
    pe.due = cyc + 2;
    if (!v) begin
      pe.valid = 1'b0; pe.en = 1'b0; pe.rgb = '0;    pe.layer = '1;
    end else if (win == N) begin
      pe.valid = 1'b1; pe.en = 1'b0; pe.rgb = curBg; pe.layer = '1;
    end else begin
      pe.valid = 1'b1; pe.en = 1'b1; pe.rgb = rgb[win*CW +: CW]; pe.layer = IW'(win);
    end
    pixQ.push_back(pe);

    ovl = ($countones(m) >= 2);
    if (wr) mShadow = cm;
    if (fs) mActive = mShadow;

    if (!modelCounting) begin
      if (fs) begin
        modelCounting = 1'b1;
        modelRun      = 0;
        modelFlag     = 1'b0;
      end
    end else if (fs) begin
      modelLast = (modelRun > 65535) ? 65535 : modelRun;
      modelRun  = ovl ? 1 : 0;
      modelFlag = ovl;
    end else if (ovl) begin
      modelRun++;
      modelFlag = 1'b1;
    end

    se.due   = cyc + 1;
    se.mask  = mActive;
    se.flag  = COLL_EN ? modelFlag : 1'b0;
    se.count = COLL_EN ? 16'(modelLast) : 16'd0;
    stQ.push_back(se);
  endtask

  // Blank for two cycles so no pixel in flight sees the background change
  task automatic setBg(input logic [CW-1:0] bg);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    curBg = bg;
  endtask

  // Raise reset between edges and check that outputs clear without a clock
  task automatic applyReset();
    #2;
    rst = 1'b1;
    bus.pix_in_valid = 1'b0;
    bus.layer_en     = '0;
    bus.cfg_wr       = 1'b0;
    bus.cfg_mask     = '0;
    bus.frame_start  = 1'b0;
    pixQ.delete();
    stQ.delete();
    mShadow = '1;
    mActive = '1;
    modelCounting = 1'b0;
    modelRun  = 0;
    modelFlag = 1'b0;
    modelLast = 0;
    #1;
    checkOutput("rst_pix_valid",   32'(bus.pix_valid),   32'd0);
    checkOutput("rst_pix_rgb",     32'(bus.pix_rgb),     32'd0);
    checkOutput("rst_pix_en",      32'(bus.pix_en),      32'd0);
    checkOutput("rst_pix_layer",   32'(bus.pix_layer),   32'hF);
    checkOutput("rst_active_mask", 32'(bus.active_mask), 32'h3FF);
    checkOutput("rst_coll_flag",   32'(bus.coll_flag),   32'd0);
    checkOutput("rst_coll_count",  32'(bus.coll_count),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare every queued expectation on the cycle it falls due
  initial begin
    pixExp_t pe;
    stExp_t  se;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (stQ.size() > 0 && stQ[0].due <= cyc) begin
        se = stQ.pop_front();
        checkOutput("active_mask", 32'(bus.active_mask), 32'(se.mask));
        checkOutput("coll_flag",   32'(bus.coll_flag),   32'(se.flag));
        checkOutput("coll_count",  32'(bus.coll_count),  32'(se.count));
      end
      while (pixQ.size() > 0 && pixQ[0].due <= cyc) begin
        pe = pixQ.pop_front();
        checkOutput("pix_valid", 32'(bus.pix_valid), 32'(pe.valid));
        checkOutput("pix_en",    32'(bus.pix_en),    32'(pe.en));
        checkOutput("pix_rgb",   32'(bus.pix_rgb),   32'(pe.rgb));
        checkOutput("pix_layer", 32'(bus.pix_layer), 32'(pe.layer));
      end
    end
  end

  // Main stimulus sequence
  initial begin
    logic [N*CW-1:0] prioRgb;
    logic [N-1:0]    prioEn;
    logic [N*CW-1:0] rr;
    logic [N-1:0]    re;
    rst = 1'b1;
    curBg = 12'h123;
    bus.layer_rgb = '0;
    bus.bg_rgb = curBg;
    applyReset();

    prioRgb = randRgb();
    prioRgb[3*CW +: CW] = 12'hF00;
    prioRgb[5*CW +: CW] = 12'h0F0;
    prioEn  = 10'b0000101000;

    // First frame boundary during blanking, entering the counting state
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Priority: layer 3 beats layer 5
    repeat (3) applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b0);

    // Background, then blanking with the same inputs
    setBg(12'h00F);
    repeat (2) applyStimulus(1'b1, '0, prioRgb, 1'b0, '0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, prioRgb, 1'b0, '0, 1'b0);
    repeat (2) applyStimulus(1'b0, prioEn, prioRgb, 1'b0, '0, 1'b0);

    // Mask timing: write mid-frame, only takes effect after frame_start
    applyStimulus(1'b1, prioEn, prioRgb, 1'b1, 10'b1111110111, 1'b0);
    repeat (3) applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b1);
    repeat (3) applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b0);

    // Write coinciding with frame_start goes straight to the active mask
    applyStimulus(1'b1, prioEn, prioRgb, 1'b1, 10'b1111111111, 1'b1);
    repeat (3) applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, prioEn, prioRgb, 1'b1, 10'b1111010111, 1'b1);
    repeat (2) applyStimulus(1'b1, prioEn, prioRgb, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, prioEn, prioRgb, 1'b1, 10'b1111111111, 1'b1);

    // Collision count: seven overlapping pixels in one frame
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (7) applyStimulus(1'b1, 10'b0000000011, randRgb(), 1'b0, '0, 1'b0);
    repeat (3) applyStimulus(1'b1, 10'b0000010000, randRgb(), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("coll_count_seven", 32'(bus.coll_count), COLL_EN ? 32'd7 : 32'd0);
    checkOutput("coll_flag_cleared", 32'(bus.coll_flag), 32'd0);

    // Overlap on the frame_start cycle reloads the counter to one
    applyStimulus(1'b1, 10'b0000000111, randRgb(), 1'b0, '0, 1'b1);
    repeat (2) applyStimulus(1'b1, 10'b0000000001, randRgb(), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Randomised traffic with occasional mask writes and frame boundaries
    setBg(CW'($urandom_range(0, 4095)));
    for (int i = 0; i < 1500; i++) begin
      rr = randRgb();
      re = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 1) == 0) re = re & N'($urandom_range(0, (1 << N) - 1));
      applyStimulus(($urandom_range(0, 7) != 0), re, rr,
                    ($urandom_range(0, 40) == 0), N'($urandom_range(0, (1 << N) - 1)),
                    ($urandom_range(0, 120) == 0));
    end

`ifdef VGA_COLLISION_EN
    // Saturation of the per-frame counter
    applyStimulus(1'b1, '0, '0, 1'b1, 10'b1111111111, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 10'b1000000001, prioRgb, 1'b0, '0, 1'b0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("coll_count_saturated", 32'(bus.coll_count), 32'hFFFF);
`endif

    // Asynchronous reset while the pipeline holds live pixels
    applyStimulus(1'b1, 10'b1111111111, 10'b1111111111, 1'b1, 10'b1111111111, 1'b1);
    repeat (3) applyStimulus(1'b1, 10'b0000000110, randRgb(), 1'b0, '0, 1'b0);
    applyReset();
    repeat (5) applyStimulus(1'b1, 10'b0000000110, randRgb(), 1'b0, '0, 1'b0);
    checkOutput("coll_flag_idle_after_reset", 32'(bus.coll_flag), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (4) applyStimulus(1'b1, 10'b0000000110, randRgb(), 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Drain the pipeline and make sure nothing was left unchecked
    repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("pix_queue_drained", 32'(pixQ.size()), 32'd0);
    checkOutput("st_queue_drained",  32'(stQ.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
